// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, LSB-first, start / data / optional parity / stop framing.
// Accepts one word per tx_start in IDLE and reports progress on registered tx_busy / tx_done.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
    logic                 parity_bit, parity_bit_n;
    logic                 tx_n, tx_busy_n, tx_done_n;

    logic                 baud_last;
    logic                 baud_penult;
    logic                 data_last;
    logic                 stop_last;

    // Bit-boundary and frame-position decodes
    always_comb begin
        baud_last   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
        baud_penult = (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
        data_last   = (bit_cnt == BIT_W'(DATA_BITS - 1));
        stop_last   = (bit_cnt == BIT_W'(STOP_BITS - 1));
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
            tx         <= tx_n;
            tx_busy    <= tx_busy_n;
            tx_done    <= tx_done_n;
        end
    end

    // Next-state logic; tx_n is the line value for the cycle after the edge
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt + CNT_W'(1);
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        tx_n         = tx;
        tx_busy_n    = tx_busy;
        tx_done_n    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                tx_n       = 1'b1;
                tx_busy_n  = 1'b0;
                if (tx_start) begin
                    shift_reg_n  = tx_data;
                    parity_bit_n = (^tx_data) ^ (PARITY_ODD != 0);
                    state_n      = ST_START;
                    tx_n         = 1'b0;
                    tx_busy_n    = 1'b1;
                end
            end

            ST_START: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    state_n    = ST_DATA;
                    tx_n       = shift_reg[0];
                end
            end

            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_n  = '0;
                    shift_reg_n = shift_reg >> 1;
                    if (data_last) begin
                        bit_cnt_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = ST_PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        tx_n      = shift_reg_n[0];
                    end
                end
            end

            ST_PARITY: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    state_n    = ST_STOP;
                    tx_n       = 1'b1;
                end
            end

            ST_STOP: begin
                tx_n = 1'b1;
                // tx_done is registered, so it is raised one edge before the last stop cycle ends
                if (stop_last && baud_penult) begin
                    tx_done_n = 1'b1;
                end
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (stop_last) begin
                        bit_cnt_n = '0;
                        state_n   = ST_IDLE;
                        tx_busy_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_n    = ST_IDLE;
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                tx_n       = 1'b1;
                tx_busy_n  = 1'b0;
            end
        endcase
    end

endmodule
